// File: rtl/apb_timer_pkg.sv
// rtl/apb_timer_pkg.sv - register map, control bit indices and bus FSM states for the APB timer
package apb_timer_pkg;

    localparam logic [3:0] REG_CTRL   = 4'h0;
    localparam logic [3:0] REG_LOAD   = 4'h4;
    localparam logic [3:0] REG_COUNT  = 4'h8;
    localparam logic [3:0] REG_STATUS = 4'hC;

    localparam int CTRL_EN          = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_IRQ_EN      = 2;

    typedef enum logic {
        IDLE,
        ACCESS
    } bus_state_e;

    function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = new_val[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/apb_timer_if.sv
// rtl/apb_timer_if.sv - APB bus bundle between the master and the timer completer
interface apb_timer_if #(
    parameter int ADDR_W = 4
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [31:0]       PWDATA;
    logic [3:0]        PSTRB;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_timer_core.sv
// rtl/apb_timer_core.sv - 32-bit down-counter with optional auto-reload and expire pulse
module apb_timer_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        auto_reload,
    input  logic [31:0] load_value,
    input  logic        start,
    output logic [31:0] count,
    output logic        expire
);

    // A start edge always reloads, so it can never coincide with an expire.
    assign expire = en && !start && (count == 32'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (start) begin
            count <= load_value;
        end else if (en) begin
            if (count != '0)      count <= count - 32'd1;
            else if (auto_reload) count <= load_value;
        end
    end

endmodule

// File: rtl/apb_timer.sv
// rtl/apb_timer.sv - APB completer with wait states, register bank and down-counter timer
module apb_timer
    import apb_timer_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int WAIT_STATES = 1
) (
    input  logic        PCLK,
    input  logic        PRESET,
    apb_timer_if.slave  bus,
    output logic        IRQ_O
);

    localparam int WCNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_STATES);

    bus_state_e        state, state_nxt;
    logic [WCNT_W-1:0] wcnt;
    logic [ADDR_W-1:0] paddr;
    logic [3:0]        addr;
    logic              ready, err, wr_commit;
    logic              ctrl_wr, load_wr, status_wr;
    logic [2:0]        ctrl, ctrl_wdata;
    logic [31:0]       load, count, rdata;
    logic              expired, expire, en_eff, auto_eff, start;

    assign paddr = bus.PADDR;
    assign addr  = {paddr[3:2], 2'b00};

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE)  wcnt <= '0;
            else if (!ready)    wcnt <= wcnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.PSEL && !bus.PENABLE) state_nxt = ACCESS;
            ACCESS:  if (!bus.PSEL || ready)       state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A master that drops PSEL mid-access gets no response at all.
    always_comb begin
        ready = (state == ACCESS) && bus.PSEL && (wcnt == WAIT_LAST);
        err   = (paddr[1:0] != 2'b00) || (bus.PWRITE && addr == REG_COUNT);
        rdata = '0;
        case (addr)
            REG_CTRL:   rdata = {29'd0, ctrl};
            REG_LOAD:   rdata = load;
            REG_COUNT:  rdata = count;
            REG_STATUS: rdata = {31'd0, expired};
            default:    rdata = '0;
        endcase
    end

    assign bus.PREADY  = ready;
    assign bus.PSLVERR = ready && err;
    assign bus.PRDATA  = (ready && !bus.PWRITE && !err) ? rdata : 32'd0;

    assign wr_commit  = ready && bus.PWRITE && !err;
    assign ctrl_wr    = wr_commit && (addr == REG_CTRL);
    assign load_wr    = wr_commit && (addr == REG_LOAD);
    assign status_wr  = wr_commit && (addr == REG_STATUS);
    assign ctrl_wdata = bus.PSTRB[0] ? bus.PWDATA[2:0] : ctrl;

    // The timer sees the control value being written this edge, so clearing
    // EN on the final count suppresses the expire.
    assign en_eff   = ctrl_wr ? ctrl_wdata[CTRL_EN]          : ctrl[CTRL_EN];
    assign auto_eff = ctrl_wr ? ctrl_wdata[CTRL_AUTO_RELOAD] : ctrl[CTRL_AUTO_RELOAD];
    assign start    = ctrl_wr && !ctrl[CTRL_EN] && ctrl_wdata[CTRL_EN];

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            ctrl    <= '0;
            load    <= '0;
            expired <= 1'b0;
        end else begin
            if (ctrl_wr) ctrl <= ctrl_wdata;
            if (load_wr) load <= strb_merge(load, bus.PWDATA, bus.PSTRB);
            if (expire)
                expired <= 1'b1;
            else if (status_wr && bus.PSTRB[0] && bus.PWDATA[0])
                expired <= 1'b0;
        end
    end

    assign IRQ_O = expired && ctrl[CTRL_IRQ_EN];

    apb_timer_core u_core (
        .clk         (PCLK),
        .rst         (PRESET),
        .en          (en_eff),
        .auto_reload (auto_eff),
        .load_value  (load),
        .start       (start),
        .count       (count),
        .expire      (expire)
    );

endmodule
